// File: rtl/mem_arbiter_pkg.sv
// Shared CPU constants: memory arbiter state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  // Default geometry of the single-port instruction/data RAM.
  localparam int unsigned MEM_ADDR_W        = 16;
  localparam int unsigned MEM_DATA_W        = 16;
  // Load/store grants allowed back to back while a fetch is kept waiting.
  localparam int unsigned MEM_MAX_LS_STREAK = 2;

  // Arbiter FSM encoding; external debug views rely on these exact codes.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } arb_state_e;

  // Counter width able to hold 0..max_streak inclusive (never zero bits).
  function automatic int unsigned streak_width(input int unsigned max_streak);
    return $clog2(max_streak + 2);
  endfunction

endpackage : mem_arbiter_pkg

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and load/store, plus the fetch-starvation streak counter.
// Latency: winner is combinational from the requests; streak updates on the granting edge.
// Backpressure: only picks while arb_en_i is high; losing requester simply stays pending.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LS_STREAK = MEM_MAX_LS_STREAK
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en_i,
  input  logic if_req_i,
  input  logic ls_req_i,
  output logic win_vld_o,
  output logic win_ls_o
);

  localparam int unsigned SW = streak_width(MAX_LS_STREAK);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          streak_full;

  // Load/store normally wins; fetch wins once it has been passed over MAX_LS_STREAK times.
  always_comb begin
    streak_full = (streak_q == SW'(MAX_LS_STREAK));
    win_vld_o   = arb_en_i && (if_req_i || ls_req_i);
    win_ls_o    = ls_req_i && !(if_req_i && streak_full);
    streak_d    = streak_q;
    if (win_vld_o) begin
      // Only an ls grant that actually overtook a waiting fetch extends the streak.
      if (win_ls_o && if_req_i) begin
        streak_d = streak_q + SW'(1);
      end else begin
        streak_d = '0;
      end
    end
  end

  // Streak register, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule : mem_arb_pick

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-port synchronous RAM.
// Latency: req seen in IDLE/RESP -> gnt next cycle; read data valid the cycle after gnt; store valid with gnt.
// Backpressure: requesters hold req until gnt; loser waits, fetch forced through after MAX_LS_STREAK ls wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = MEM_ADDR_W,
  parameter int unsigned DATA_W        = MEM_DATA_W,
  parameter int unsigned MAX_LS_STREAK = MEM_MAX_LS_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  // Load/store port
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_valid,
  output logic [DATA_W-1:0] ls_rdata,
  // RAM port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              win_ls_q, win_ls_d;     // 1: current access belongs to load/store
  logic              store_q, store_d;       // current access is a store
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic arb_en;
  logic win_vld;
  logic win_ls;

  // Arbitration slots are IDLE and RESP; RESP->ISSUE gives back-to-back reads every 2 cycles.
  assign arb_en = (state_q == IDLE) || (state_q == RESP);

  mem_arb_pick #(
    .MAX_LS_STREAK(MAX_LS_STREAK)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .arb_en_i (arb_en),
    .if_req_i (if_req),
    .ls_req_i (ls_req),
    .win_vld_o(win_vld),
    .win_ls_o (win_ls)
  );

  // Next state, access latching on a win, and read-data capture in RESP.
  always_comb begin
    state_d     = state_q;
    win_ls_d    = win_ls_q;
    store_d     = store_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;

    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP) begin
          if (win_ls_q) begin
            ls_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
        end
        if (win_vld) begin
          state_d  = ISSUE;
          win_ls_d = win_ls;
          store_d  = win_ls && ls_we;
          if (win_ls) begin
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
          end else begin
            mem_addr_d  = if_addr;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // A store completes in its issue cycle; reads wait one cycle for RAM data.
        state_d = store_q ? IDLE : RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Port-facing strobes are decoded from the registered state so they cannot glitch on inputs.
  always_comb begin
    busy     = (state_q != IDLE);
    if_gnt   = (state_q == ISSUE) && !win_ls_q;
    ls_gnt   = (state_q == ISSUE) &&  win_ls_q;
    mem_we   = (state_q == ISSUE) &&  win_ls_q && store_q;
    if_valid = (state_q == RESP)  && !win_ls_q;
    ls_valid = ((state_q == ISSUE) && win_ls_q && store_q) ||
               ((state_q == RESP)  && win_ls_q);
    if_rdata = if_valid                      ? mem_rdata : if_rdata_q;
    ls_rdata = ((state_q == RESP) && win_ls_q) ? mem_rdata : ls_rdata_q;
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // State and datapath registers; reset drops any in-flight access without a valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      win_ls_q    <= 1'b0;
      store_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_ls_q    <= win_ls_d;
      store_q     <= store_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter MAX_LS_STREAK, default 2, maximum consecutive load/store grants while fetch waits.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  fetch request; held with if_addr until if_gnt.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_gnt  out  1  one-cycle pulse when the fetch address is issued to memory.
REQ-009 if_valid  out  1  one-cycle pulse; if_rdata holds the fetched word.
REQ-010 if_rdata  out  DATA_W  fetch read data.
REQ-011 ls_req  in  1  load/store request; held with ls_we/ls_addr/ls_wdata until ls_gnt.
REQ-012 ls_we  in  1  1 = store, 0 = load.
REQ-013 ls_addr  in  ADDR_W  load/store address.
REQ-014 ls_wdata  in  DATA_W  store data.
REQ-015 ls_gnt  out  1  one-cycle pulse when the load/store is issued.
REQ-016 ls_valid  out  1  one-cycle pulse: load data ready, or store committed.
REQ-017 ls_rdata  out  DATA_W  load read data.
REQ-018 mem_addr  out  ADDR_W  registered address to single-port synchronous RAM.
REQ-019 mem_wdata  out  DATA_W  registered write data.
REQ-020 mem_we  out  1  RAM write enable.
REQ-021 mem_rdata  in  DATA_W  RAM read data, valid one cycle after address issue.
REQ-022 busy  out  1  high whenever state is not IDLE.

Function
REQ-023 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-024 Arbitration SHALL occur only in IDLE and RESP; a winner moves the FSM to ISSUE on the next edge, and mem_addr, mem_wdata and the store flag are latched on that edge.
REQ-025 With no request pending, IDLE SHALL stay in IDLE and RESP SHALL go to IDLE.
REQ-026 In ISSUE, gnt of the winner SHALL be 1, and mem_we SHALL be 1 only for a store.
REQ-027 A store SHALL pulse ls_valid in its ISSUE cycle and then go to IDLE, with no RESP cycle.
REQ-028 A read SHALL go ISSUE→RESP; in RESP the winner's valid SHALL be 1 and its rdata SHALL equal mem_rdata.
REQ-029 if_rdata and ls_rdata SHALL hold their last RESP value outside RESP.
REQ-030 mem_addr and mem_wdata SHALL remain stable from ISSUE through RESP.
REQ-031 mem_we SHALL be 0 in IDLE and RESP.
REQ-032 Priority: load/store SHALL win over fetch, except as in REQ-033.
REQ-033 Streak counter: on every ls grant made while if_req=1, increment the counter; when counter==MAX_LS_STREAK and both requests are pending, grant fetch.
REQ-034 The streak counter SHALL clear on any fetch grant, and on any ls grant made while if_req=0.
REQ-035 Back-to-back reads SHALL sustain one access per 2 cycles (RESP→ISSUE).
REQ-036 A request deasserted before its gnt SHALL be dropped silently, with no gnt or valid.
REQ-037 At most one gnt and one valid SHALL be high in any cycle.

Reset
REQ-038 Asserting rst SHALL immediately force: state=IDLE, all gnt/valid=0, mem_we=0, busy=0, mem_addr=0, mem_wdata=0, rdata outputs=0, streak=0.
REQ-039 Reset mid-access SHALL discard the in-flight read with no valid pulse; the requester reissues.
REQ-040 Release of reset SHALL take effect on the first posedge clk with rst=1.

Structure
REQ-041 The state encoding (IDLE=2'b00, ISSUE=2'b01, RESP=2'b10) and the default widths SHALL live in the shared CPU constants package.
REQ-042 Winner selection and streak counter logic SHALL be a single sub-module, mem_arb_pick.

Verification
REQ-043 Fetch only: if_req=1, if_addr=0x0010, RAM[0x0010]=0xA5A5 → if_gnt in cycle 2, then if_valid with if_rdata=0xA5A5 in cycle 3.
REQ-044 Store: ls_req=1, ls_we=1, ls_addr=0x0200, ls_wdata=0x1234 → mem_we=1 and ls_valid=1 for exactly one cycle; a later load from 0x0200 returns 0x1234.
REQ-045 Simultaneous requests, with if_req and ls_req both held and each re-requesting after gnt → grant order LS, LS, IF, LS, LS, IF.
REQ-046 rst pulled low during RESP of a load → ls_valid never pulses, mem_we=0 and busy=0 immediately, FSM in IDLE.
REQ-047 Read-to-read timing: back-to-back fetches to 0x0000 and 0x0001 → if_gnt pulses two cycles apart, and each if_valid follows its gnt by one cycle.
